// File: rtl/inst_fetch_controller.sv
// Instruction fetch front-end: owns the PC, reads the combinational
// instruction memory, and buffers fetched words in a small prefetch FIFO
// presented to decode over a valid/ready handshake. Illegal fetches
// enqueue a fault entry and halt; a redirect flushes and restarts.
module inst_fetch_controller #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          MEM_BYTES = 152,
  parameter int          DEPTH     = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] inst_address,
  input  logic [31:0] instruction,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [63:0] fetch_pc,
  output logic [31:0] fetch_inst,
  output logic        fetch_fault,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        halted
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [63:0]      LAST_ADDR = 64'(MEM_BYTES - 4);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

  typedef enum logic {RUN, HALT} state_t;

  state_t state_q, state_d;

  logic [63:0]      pc_q;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;

  logic [63:0] pc_mem    [DEPTH];
  logic [31:0] inst_mem  [DEPTH];
  logic        fault_mem [DEPTH];

  logic legal, pop, push;

  // Word-aligned and inside memory; the upper bound also guards against
  // ever reaching the 64-bit wrap of pc+4.
  function automatic logic addr_legal(input logic [63:0] a);
    return (a[1:0] == 2'b00) && (a <= LAST_ADDR);
  endfunction

  assign legal = addr_legal(pc_q);
  assign pop   = fetch_valid && fetch_ready;
  // A redirect suppresses the push of the stale PC in its cycle.
  assign push  = (state_q == RUN) && !redirect_valid &&
                 ((count < FULL_CNT) || pop);

  // Next-state: redirect always restarts, an illegal fetch halts.
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = RUN;
    end else if (push && !legal) begin
      state_d = HALT;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // PC and FIFO bookkeeping; redirect flushes after any same-cycle pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      pc_q   <= redirect_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        if (legal) begin
          pc_q <= pc_q + 64'd4;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are meaningless until counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= pc_q;
      inst_mem[wr_ptr]  <= legal ? instruction : 32'h0;
      fault_mem[wr_ptr] <= !legal;
    end
  end

  assign inst_address = pc_q;
  assign fetch_valid  = (count != '0);
  assign fetch_pc     = fetch_valid ? pc_mem[rd_ptr]    : 64'h0;
  assign fetch_inst   = fetch_valid ? inst_mem[rd_ptr]  : 32'h0;
  assign fetch_fault  = fetch_valid ? fault_mem[rd_ptr] : 1'b0;
  assign halted       = (state_q == HALT);

endmodule

// File: tb/tb_inst_fetch_controller.sv
// Bench for inst_fetch_controller: directed phases push the expected
// accepted entries into a queue; a monitor compares every handshake.
module tb_inst_fetch_controller;

  logic        clk;
  logic        reset;
  logic [63:0] inst_address;
  logic [31:0] instruction;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [63:0] fetch_pc;
  logic [31:0] fetch_inst;
  logic        fetch_fault;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halted;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        fault;
  } ent_t;

  ent_t expq[$];
  int   tests = 0;
  int   fails = 0;
  logic [31:0] rom [38];

  inst_fetch_controller #(.RESET_PC(64'h0), .MEM_BYTES(152), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .inst_address(inst_address),
    .instruction(instruction), .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready), .fetch_pc(fetch_pc), .fetch_inst(fetch_inst),
    .fetch_fault(fetch_fault), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halted(halted)
  );

  // Combinational memory model; out-of-range reads return junk.
  assign instruction = (inst_address < 64'd152) ? rom[inst_address[7:2]]
                                                 : 32'hdeadbeef;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: every accepted head entry is checked against the queue.
  always @(negedge clk) begin
    if (reset === 1'b0 && fetch_valid === 1'b1 && fetch_ready === 1'b1) begin
      tests++;
      if (expq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_entry: got pc=%0d inst=%h fault=%b, required none",
                 fetch_pc, fetch_inst, fetch_fault);
      end else begin
        ent_t e;
        e = expq.pop_front();
        if (fetch_pc !== e.pc || fetch_inst !== e.inst || fetch_fault !== e.fault) begin
          fails++;
          $display("FAIL entry: got pc=%0d inst=%h fault=%b, required pc=%0d inst=%h fault=%b",
                   fetch_pc, fetch_inst, fetch_fault, e.pc, e.inst, e.fault);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic expect_ent(input logic [63:0] pc, input logic [31:0] inst, input logic fault);
    ent_t e;
    e.pc = pc;
    e.inst = inst;
    e.fault = fault;
    expq.push_back(e);
  endtask

  task automatic drain(input string name, input int budget, output int n);
    n = 0;
    while (expq.size() != 0 && n < budget) begin
      step();
      n++;
    end
    if (expq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got %0d entries outstanding, required 0", name, expq.size());
      expq.delete();
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    redirect_valid = 1'b0;
    repeat (n) step();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 38; i++) rom[i] = 32'h0a000000 | i;
    rom[0]  = 32'h00000000;
    rom[1]  = 32'hff810113;
    rom[2]  = 32'h00a12223;
    rom[3]  = 32'h00b12023;
    rom[14] = 32'h04058a63;
    rom[15] = 32'h004000ef;
    rom[37] = 32'h00810113;

    reset = 1'b1;
    fetch_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 64'h0;

    // Reset state.
    repeat (2) step();
    chk("reset_valid", 64'(fetch_valid), 64'd0);
    chk("reset_halted", 64'(halted), 64'd0);
    chk("reset_addr", inst_address, 64'd0);
    chk("reset_pc_out", fetch_pc, 64'd0);
    chk("reset_inst_out", 64'(fetch_inst), 64'd0);
    chk("reset_fault_out", 64'(fetch_fault), 64'd0);

    // Streaming after reset release with ready high.
    expect_ent(64'd0, 32'h00000000, 1'b0);
    expect_ent(64'd4, 32'hff810113, 1'b0);
    expect_ent(64'd8, 32'h00a12223, 1'b0);
    expect_ent(64'd12, 32'h00b12023, 1'b0);
    reset = 1'b0;
    drain("stream", 20, n);
    fetch_ready = 1'b0;

    // Backpressure: FIFO fills, PC stalls, then drains without a bubble.
    do_reset(2);
    repeat (5) step();
    chk("bp_addr", inst_address, 64'd8);
    chk("bp_valid", 64'(fetch_valid), 64'd1);
    chk("bp_head_pc", fetch_pc, 64'd0);
    expect_ent(64'd0, 32'h00000000, 1'b0);
    expect_ent(64'd4, 32'hff810113, 1'b0);
    expect_ent(64'd8, 32'h00a12223, 1'b0);
    fetch_ready = 1'b1;
    drain("bp", 20, n);
    chk("bp_cycles", 64'(n), 64'd3);
    fetch_ready = 1'b0;

    // Redirect while full with a same-cycle pop.
    do_reset(2);
    repeat (4) step();
    expect_ent(64'd0, 32'h00000000, 1'b0);
    expect_ent(64'd56, 32'h04058a63, 1'b0);
    expect_ent(64'd60, 32'h004000ef, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc = 64'd56;
    fetch_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    chk("redir_bubble", 64'(fetch_valid), 64'd0);
    chk("redir_popped_once", 64'(expq.size()), 64'd2);
    drain("redir", 20, n);
    fetch_ready = 1'b0;

    // Run off the end of memory into a fault and HALT.
    expect_ent(64'd140, 32'h0a000023, 1'b0);
    expect_ent(64'd144, 32'h0a000024, 1'b0);
    expect_ent(64'd148, 32'h00810113, 1'b0);
    expect_ent(64'd152, 32'h00000000, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc = 64'd140;
    step();
    redirect_valid = 1'b0;
    fetch_ready = 1'b1;
    drain("end", 20, n);
    repeat (5) step();
    chk("end_halted", 64'(halted), 64'd1);
    chk("end_addr_hold", inst_address, 64'd152);
    chk("end_empty", 64'(fetch_valid), 64'd0);

    // Redirect out of HALT.
    fetch_ready = 1'b0;
    expect_ent(64'd0, 32'h00000000, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc = 64'd0;
    step();
    redirect_valid = 1'b0;
    chk("resume_run", 64'(halted), 64'd0);
    fetch_ready = 1'b1;
    drain("resume", 20, n);
    fetch_ready = 1'b0;

    // Misaligned redirect target faults immediately.
    expect_ent(64'd6, 32'h00000000, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc = 64'd6;
    step();
    redirect_valid = 1'b0;
    fetch_ready = 1'b1;
    drain("misalign", 20, n);
    step();
    chk("misalign_halted", 64'(halted), 64'd1);
    chk("misalign_addr", inst_address, 64'd6);
    fetch_ready = 1'b0;

    // Reset mid-stream overrides a simultaneous redirect.
    redirect_valid = 1'b1;
    redirect_pc = 64'd20;
    step();
    redirect_valid = 1'b0;
    repeat (3) step();
    chk("pre_reset_head", fetch_pc, 64'd20);
    reset = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'd100;
    step();
    reset = 1'b0;
    redirect_valid = 1'b0;
    chk("mid_reset_valid", 64'(fetch_valid), 64'd0);
    chk("mid_reset_addr", inst_address, 64'd0);
    chk("mid_reset_halted", 64'(halted), 64'd0);
    expect_ent(64'd0, 32'h00000000, 1'b0);
    expect_ent(64'd4, 32'hff810113, 1'b0);
    fetch_ready = 1'b1;
    drain("mid_reset", 20, n);
    fetch_ready = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
